// File: rtl/iir_response_capture.sv
// Records DEPTH consecutive iir output samples into RAM, then plays them back over a valid/ready stream.
// Optional peak |y| tracking is built only when IIR_CAPTURE_PEAK_EN is defined.
module iir_response_capture #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic [DATA_W-1:0] y,
  output logic              busy,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_last,
  output logic              cap_done,
  output logic [DATA_W-1:0] peak_abs,
  output logic [1:0]        state_dbg
);

  // Playback handshake: a sample transfers on any edge where rd_valid && rd_ready;
  // while rd_valid=1 and rd_ready=0 the rd_data/rd_last/rd_valid outputs hold.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CAPTURE = 2'd1, S_DRAIN = 2'd2} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              rd_all;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] out_d, pf_d;
  logic              out_v, out_last, pf_v, pf_last;
  logic              arm_go, fire, take, issue;

  always_comb begin
    arm_go = (state == S_IDLE) && arm;
    fire   = out_v && rd_ready;
    take   = fire || !out_v;
    // A read may be issued whenever the prefetch slot is free or is being drained this edge.
    issue  = (state == S_DRAIN) && !rd_all && (!pf_v || fire);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (arm) state_nxt = S_CAPTURE;
      S_CAPTURE: if (wr_ptr == LAST_ADDR) state_nxt = S_DRAIN;
      S_DRAIN:   if (fire && out_last) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (state == S_CAPTURE) mem[wr_ptr] <= y;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_all   <= 1'b0;
      out_d    <= '0;
      out_v    <= 1'b0;
      out_last <= 1'b0;
      pf_d     <= '0;
      pf_v     <= 1'b0;
      pf_last  <= 1'b0;
      cap_done <= 1'b0;
    end else begin
      cap_done <= (state == S_DRAIN) && fire && out_last;
      if (arm_go) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        rd_all <= 1'b0;
        out_v  <= 1'b0;
        pf_v   <= 1'b0;
      end else begin
        if (state == S_CAPTURE) wr_ptr <= wr_ptr + 1'b1;
        if (issue) begin
          rd_ptr <= rd_ptr + 1'b1;
          if (rd_ptr == LAST_ADDR) rd_all <= 1'b1;
        end
        if (take) begin
          if (pf_v) begin
            out_d    <= pf_d;
            out_last <= pf_last;
            out_v    <= 1'b1;
            pf_v     <= issue;
            if (issue) begin
              pf_d    <= mem[rd_ptr];
              pf_last <= (rd_ptr == LAST_ADDR);
            end
          end else if (issue) begin
            out_d    <= mem[rd_ptr];
            out_last <= (rd_ptr == LAST_ADDR);
            out_v    <= 1'b1;
          end else begin
            out_v    <= 1'b0;
            out_last <= 1'b0;
          end
        end else if (issue) begin
          pf_d    <= mem[rd_ptr];
          pf_last <= (rd_ptr == LAST_ADDR);
          pf_v    <= 1'b1;
        end
      end
    end
  end

  assign busy      = (state != S_IDLE);
  assign rd_data   = out_d;
  assign rd_valid  = out_v;
  assign rd_last   = out_v && out_last;
  assign state_dbg = state;

`ifdef IIR_CAPTURE_PEAK_EN
  localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};
  logic [DATA_W-1:0] y_abs, peak_q;

  // The most negative input has no positive twin, so its magnitude saturates.
  always_comb begin
    if (y == SMIN)         y_abs = ~SMIN;
    else if (y[DATA_W-1])  y_abs = -y;
    else                   y_abs = y;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                       peak_q <= '0;
    else if (arm_go)                                peak_q <= '0;
    else if (state == S_CAPTURE && y_abs > peak_q)  peak_q <= y_abs;
  end

  assign peak_abs = peak_q;
`else
  assign peak_abs = '0;
`endif

endmodule

// File: tb/tb_iir_response_capture.sv
// Randomized bench for iir_response_capture: a queue-based model of the captured window
// is compared against the playback stream, plus reset, abort and peak scenarios.
module tb_iir_response_capture;
  localparam int DEPTH = 256;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          arm = 1'b0;
  logic [DW-1:0] y = '0;
  logic          rd_ready = 1'b0;
  logic          busy, rd_valid, rd_last, cap_done;
  logic [DW-1:0] rd_data, peak_abs;
  logic [1:0]    state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] win [DEPTH];
  logic [DW-1:0] exp_q [$];

  iir_response_capture #(.DEPTH(DEPTH), .ADDR_W(8), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .arm(arm), .y(y), .busy(busy),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
    .cap_done(cap_done), .peak_abs(peak_abs), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [DW-1:0] mag(input logic [DW-1:0] v);
    longint s;
    s = longint'($signed(v));
    if (s < 0) s = -s;
    if (s > 64'sh7FFFFFFF) s = 64'sh7FFFFFFF;
    return DW'(s);
  endfunction

  // rmode: 0 always ready, 1 pattern 1,0,0,1, 2 random. abort_at >= 0 resets after that many accepts.
  task automatic run_window(input int rmode, input int abort_at, input bit poke);
    int got = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    bit aborted = 1'b0;
    logic [DW-1:0] prev_d = '0;
    logic prev_l = 1'b0;
    logic [DW-1:0] e;
    logic [DW-1:0] pk = '0;
    exp_q.delete();
    @(negedge clk);
    arm = 1'b1;
    y = $urandom;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      arm = poke && (i == 5);
      y = win[i];
      exp_q.push_back(win[i]);
      if (mag(win[i]) > pk) pk = mag(win[i]);
      if (i == 10) check("busy_capture", {31'b0, busy}, 32'd1);
    end
    @(negedge clk);
    arm = 1'b0;
    y = $urandom;
    check("busy_drain_entry", {31'b0, busy}, 32'd1);
    check("valid_latency", {31'b0, rd_valid}, 32'd0);
`ifdef IIR_CAPTURE_PEAK_EN
    check("peak_entry", peak_abs, pk);
`else
    check("peak_entry", peak_abs, 32'd0);
`endif
    while (got < DEPTH && cyc < 4000 && !aborted) begin
      case (rmode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      arm = poke && (cyc == 20);
      if (stalled) begin
        check("stall_valid", {31'b0, rd_valid}, 32'd1);
        check("stall_data", rd_data, prev_d);
        check("stall_last", {31'b0, rd_last}, {31'b0, prev_l});
      end
      check("cap_done_early", {31'b0, cap_done}, 32'd0);
      if (rd_valid && rd_ready) begin
        e = exp_q.pop_front();
        check("sample", rd_data, e);
        check("last_flag", {31'b0, rd_last}, {31'b0, (got == DEPTH - 1)});
        got++;
        if (got == DEPTH && poke) arm = 1'b1;
      end
      stalled = rd_valid && !rd_ready;
      prev_d = rd_data;
      prev_l = rd_last;
      cyc++;
      @(negedge clk);
      if (abort_at >= 0 && got == abort_at) aborted = 1'b1;
    end
    arm = 1'b0;
    if (aborted) begin
      rst = 1'b0;
      #1;
      check("abort_valid", {31'b0, rd_valid}, 32'd0);
      check("abort_busy", {31'b0, busy}, 32'd0);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        arm = ~arm;
        check("abort_cap_done", {31'b0, cap_done}, 32'd0);
      end
      arm = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("abort_idle", {31'b0, busy}, 32'd0);
      return;
    end
    if (got < DEPTH) begin
      check("drain_timeout", got, DEPTH);
      return;
    end
    check("valid_after_last", {31'b0, rd_valid}, 32'd0);
    check("cap_done_pulse", {31'b0, cap_done}, 32'd1);
    check("busy_after_last", {31'b0, busy}, 32'd0);
    @(negedge clk);
    check("cap_done_single", {31'b0, cap_done}, 32'd0);
    check("busy_stays_idle", {31'b0, busy}, 32'd0);
    rd_ready = 1'b0;
  endtask

  initial begin
    // reset with arm toggling
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      arm = ~arm;
      y = $urandom;
    end
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_valid", {31'b0, rd_valid}, 32'd0);
    check("rst_data", rd_data, 32'd0);
    check("rst_last", {31'b0, rd_last}, 32'd0);
    check("rst_cap_done", {31'b0, cap_done}, 32'd0);
    check("rst_peak", peak_abs, 32'd0);
    arm = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_busy", {31'b0, busy}, 32'd0);
      check("idle_valid", {31'b0, rd_valid}, 32'd0);
    end

    // impulse
    for (int i = 0; i < DEPTH; i++) win[i] = (i == 0) ? 32'h0000_1000 : 32'h0;
    run_window(0, -1, 1'b0);

    // ramp with 1,0,0,1 backpressure
    for (int i = 0; i < DEPTH; i++) win[i] = DW'(i);
    run_window(1, -1, 1'b0);

    // random data, random backpressure, arm poked while busy and on final handshake
    for (int i = 0; i < DEPTH; i++) win[i] = $urandom;
    run_window(2, -1, 1'b1);

    // reset mid-drain, then a fresh window
    for (int i = 0; i < DEPTH; i++) win[i] = $urandom;
    run_window(0, 100, 1'b0);
    for (int i = 0; i < DEPTH; i++) win[i] = $urandom;
    run_window(2, -1, 1'b0);

    // peak corners among small random values
    for (int i = 0; i < DEPTH; i++) win[i] = DW'($urandom_range(0, 1000)) - 32'd500;
    win[$urandom_range(0, 80)]    = 32'h0000_0005;
    win[$urandom_range(90, 160)]  = 32'hFFFF_0000;
    win[$urandom_range(170, 255)] = 32'h8000_0000;
    run_window(0, -1, 1'b0);
`ifdef IIR_CAPTURE_PEAK_EN
    check("peak_saturated", peak_abs, 32'h7FFF_FFFF);
`else
    check("peak_disabled", peak_abs, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
